// File: rtl/bcd_stream_decoder.sv
// bcd_stream_decoder: unpacks a packed multi-digit BCD word into one-hot digits, LSD first
module bcd_stream_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              out_onehot,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_err
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);
  state_t state, state_n;
  logic [4*NUM_DIGITS-1:0] sh, sh_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0] digit;
  logic act;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
    end
  end
  // the current digit always sits in the low nibble; each handshake shifts the next one down
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    if (state == IDLE && in_valid) begin
      state_n = EMIT;
      sh_n = in_bcd;
      idx_n = '0;
    end else if (state == EMIT && out_ready) begin
      state_n = (idx == LAST) ? IDLE : EMIT;
      sh_n = sh >> 4;
      idx_n = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end
  assign digit = sh[3:0];
  assign act = rst_n && state == EMIT;
  assign in_ready = rst_n && state == IDLE;
  assign out_valid = act;
  assign out_onehot = (act && digit < 4'd10) ? 10'(1) << digit : '0;
  assign out_err = act && digit >= 4'd10;
  assign out_idx = act ? idx : '0;
  assign out_last = act && idx == LAST;
endmodule
